bounce_generator: RTL and testbench

- Synthesizable contact-bounce emulator. It is the stimulus-side counterpart of the debouncer.
- Takes a clean level and reproduces each change on the output as a burst of pseudo-random toggles that settles to the new level.
- Used in self-test builds to drive debouncer and capture-channel inputs with repeatable, LFSR-seeded bounce.

---
 rtl/bounce_generator.sv | 115 +++++++++++
 tb/tb_bounce_generator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_generator.sv
// Contact-bounce emulator: turns each clean level change into a burst of
// pseudo-random toggles that settles to the new level. The LFSR is seeded at
// reset and only advances when a segment is loaded, so every run is repeatable.
module bounce_generator #(
  parameter int          GAP_BITS = 2,
  parameter int          BOUNCES  = 3,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clean_in,
  output logic        out,
  output logic        busy,
  output logic [15:0] edge_count
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam int CNT_W = $clog2(BOUNCES + 1);
  localparam logic [CNT_W-1:0] LAST_TOGGLE = CNT_W'(BOUNCES);
  localparam logic [CNT_W-1:0] FIRST_TOGGLE = CNT_W'(1);
  localparam logic [GAP_BITS-1:0] TIMER_STEP = GAP_BITS'(1);

  typedef enum logic {
    IDLE,
    BOUNCE
  } state_t;

  state_t              state;
  logic                in_q;
  logic                target;
  logic [GAP_BITS-1:0] timer;
  logic [CNT_W-1:0]    toggle_cnt;
  logic [15:0]         lfsr;
  logic [15:0]         lfsr_next;
  logic                re_edge;
  logic                seg_end;
  logic                last_seg;
  logic                out_d;

  // Fibonacci LFSR successor, taps 16/14/13/11.
  always_comb begin
    lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Decode the burst events and the next output level; the edge counter
  // needs the next level in the same cycle the output register takes it.
  always_comb begin
    re_edge  = (in_q != target);
    seg_end  = (state == BOUNCE) && (timer == '0);
    last_seg = (toggle_cnt == LAST_TOGGLE);
    out_d    = out;
    if (!en) begin
      out_d = in_q;
    end else if (re_edge) begin
      out_d = ~out;
    end else if (seg_end) begin
      out_d = last_seg ? target : ~out;
    end
  end

  // Burst sequencer: a new input level (re)starts the burst, each expired
  // segment toggles the output until the last toggle, then it settles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q       <= 1'b0;
      target     <= 1'b0;
      out        <= 1'b0;
      busy       <= 1'b0;
      state      <= IDLE;
      timer      <= '0;
      toggle_cnt <= '0;
      lfsr       <= SEED_EFF;
    end else begin
      in_q <= clean_in;
      out  <= out_d;
      if (!en) begin
        target     <= in_q;
        state      <= IDLE;
        busy       <= 1'b0;
        toggle_cnt <= '0;
        timer      <= '0;
      end else if (re_edge) begin
        target     <= in_q;
        toggle_cnt <= FIRST_TOGGLE;
        timer      <= lfsr[GAP_BITS-1:0];
        lfsr       <= lfsr_next;
        state      <= BOUNCE;
        busy       <= 1'b1;
      end else if (state == BOUNCE) begin
        if (timer != '0) begin
          timer <= timer - TIMER_STEP;
        end else if (last_seg) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          toggle_cnt <= toggle_cnt + FIRST_TOGGLE;
          timer      <= lfsr[GAP_BITS-1:0];
          lfsr       <= lfsr_next;
        end
      end
    end
  end

  // Saturating count of output transitions, in both modes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_count <= 16'h0000;
    end else if ((out_d != out) && (edge_count != 16'hFFFF)) begin
      edge_count <= edge_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_bounce_generator.sv
// Testbench for bounce_generator: a behavioural model predicts each cycle's
// outputs into a scoreboard queue, plus hand-derived checks of key scenarios.
`timescale 1ns/1ps
module tb_bounce_generator;

  localparam int          GAP_BITS = 2;
  localparam int          BOUNCES  = 3;
  localparam logic [15:0] SEED     = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clean_in;
  logic        out;
  logic        busy;
  logic [15:0] edge_count;

  bounce_generator #(
    .GAP_BITS(GAP_BITS),
    .BOUNCES (BOUNCES),
    .SEED    (SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clean_in  (clean_in),
    .out       (out),
    .busy      (busy),
    .edge_count(edge_count)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  typedef struct packed {
    logic        expOut;
    logic        expBusy;
    logic [15:0] expEc;
  } expect_t;

  expect_t expQ[$];
  int nChecks = 0;
  int nPassed = 0;

  // Reference model state
  logic        mInq;
  logic        mTarget;
  logic        mOut;
  logic        mBusy;
  int          mTimer;
  int          mTog;
  logic [15:0] mLfsr;
  logic [15:0] mEc;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] want);
    nChecks++;
    if (got !== want) begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
    end else begin
      nPassed++;
    end
  endtask

  task automatic resetModel();
    mInq    = 1'b0;
    mTarget = 1'b0;
    mOut    = 1'b0;
    mBusy   = 1'b0;
    mTimer  = 0;
    mTog    = 0;
    mLfsr   = (SEED == 16'h0000) ? 16'h0001 : SEED;
    mEc     = 16'h0000;
    expQ.delete();
  endtask

  task automatic loadSegment();
    logic fb;
    mTimer = int'(mLfsr) % (1 << GAP_BITS);
    fb     = mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10];
    mLfsr  = {mLfsr[14:0], fb};
  endtask

  // One clock of the behavioural model, using the pre-edge inputs.
  task automatic modelStep(input logic e, input logic c);
    logic nOut;
    nOut = mOut;
    if (!e) begin
      nOut    = mInq;
      mTarget = mInq;
      mBusy   = 1'b0;
      mTog    = 0;
      mTimer  = 0;
    end else if (mInq != mTarget) begin
      mTarget = mInq;
      nOut    = ~mOut;
      mTog    = 1;
      mBusy   = 1'b1;
      loadSegment();
    end else if (mBusy) begin
      if (mTimer > 0) begin
        mTimer = mTimer - 1;
      end else if (mTog == BOUNCES) begin
        nOut  = mTarget;
        mBusy = 1'b0;
      end else begin
        nOut = ~mOut;
        mTog = mTog + 1;
        loadSegment();
      end
    end
    if ((nOut != mOut) && (mEc != 16'hFFFF)) mEc = mEc + 16'd1;
    mOut = nOut;
    mInq = c;
  endtask

  // Drive one cycle of inputs, predict into the queue, then compare after the edge.
  task automatic applyStimulus(input logic e, input logic c);
    expect_t x;
    en       = e;
    clean_in = c;
    modelStep(e, c);
    x.expOut  = mOut;
    x.expBusy = mBusy;
    x.expEc   = mEc;
    expQ.push_back(x);
    @(posedge clk);
    #1;
    x = expQ.pop_front();
    checkOutput("sb_out", {15'd0, out}, {15'd0, x.expOut});
    checkOutput("sb_busy", {15'd0, busy}, {15'd0, x.expBusy});
    checkOutput("sb_edge_count", edge_count, x.expEc);
  endtask

  // Guard against a hung run.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [11:0] expOutVec;
    logic [11:0] expBusyVec;
    logic [15:0] ecBefore;
    logic        c;

    expOutVec  = 12'b111110000110;
    expBusyVec = 12'b011111111110;

    rst      = 1'b1;
    en       = 1'b1;
    clean_in = 1'b0;
    resetModel();
    @(posedge clk);
    #1;
    checkOutput("reset_out", {15'd0, out}, 16'd0);
    checkOutput("reset_busy", {15'd0, busy}, 16'd0);
    checkOutput("reset_edge_count", edge_count, 16'd0);
    rst = 1'b0;

    // Nominal rise: segments 2, 4, 4 from seed ACE1
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput($sformatf("rise_out_E%0d", i), {15'd0, out}, {15'd0, expOutVec[i]});
      checkOutput($sformatf("rise_busy_E%0d", i), {15'd0, busy}, {15'd0, expBusyVec[i]});
    end
    checkOutput("rise_edge_count", edge_count, 16'd3);

    // Fall after settle
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("fall_out", {15'd0, out}, 16'd0);
    checkOutput("fall_busy", {15'd0, busy}, 16'd0);
    checkOutput("fall_edge_count", edge_count, 16'd6);

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    #2;
    clean_in = 1'b0;
    rst      = 1'b1;
    #1;
    checkOutput("midreset_out", {15'd0, out}, 16'd0);
    checkOutput("midreset_busy", {15'd0, busy}, 16'd0);
    checkOutput("midreset_edge_count", edge_count, 16'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    resetModel();

    // Re-edge mid-burst from a fresh seed: first segment is 2 cycles again
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("reedge_out_E1", {15'd0, out}, 16'd1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("reedge_out_E2", {15'd0, out}, 16'd1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("reedge_out_E3", {15'd0, out}, 16'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("reedge_out_E4", {15'd0, out}, 16'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("reedge_out_E5", {15'd0, out}, 16'd1);
    checkOutput("reedge_busy_E5", {15'd0, busy}, 16'd1);
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("reedge_final_out", {15'd0, out}, 16'd0);
    checkOutput("reedge_final_busy", {15'd0, busy}, 16'd0);

    // Bypass: output follows the input two edges later
    ecBefore = edge_count;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("bypass_out_E2", {15'd0, out}, 16'd1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("bypass_out_E4", {15'd0, out}, 16'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("bypass_edge_delta", edge_count - ecBefore, 16'd2);

    // Drop en at E4 of a burst, then raise it with out already at in_q
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("dropen_out", {15'd0, out}, 16'd1);
    checkOutput("dropen_busy", {15'd0, busy}, 16'd0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("raiseen_busy", {15'd0, busy}, 16'd0);
    checkOutput("raiseen_out", {15'd0, out}, 16'd1);

    // Toggle stress until the edge counter saturates
    c = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      c = ~c;
      applyStimulus(1'b1, c);
    end
    checkOutput("sat_edge_count", edge_count, 16'hFFFF);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, c);
    checkOutput("sat_hold_edge_count", edge_count, 16'hFFFF);
    checkOutput("sat_settle_busy", {15'd0, busy}, 16'd0);
    checkOutput("sat_settle_out", {15'd0, out}, {15'd0, c});

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
